// File: rtl/mux5_rr_arbiter_pkg.sv
// rtl/mux5_rr_arbiter_pkg.sv - shared types and constants for the 5-way round-robin mux arbiter
package mux5_rr_arbiter_pkg;

  localparam int N_REQ = 5;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] SEL_IN0 = 3'b000;
  localparam logic [SEL_W-1:0] SEL_IN1 = 3'b001;
  localparam logic [SEL_W-1:0] SEL_IN2 = 3'b010;
  localparam logic [SEL_W-1:0] SEL_IN3 = 3'b011;
  localparam logic [SEL_W-1:0] SEL_IN4 = 3'b100;

  // Owner index to one-hot grant; unused codes map to no grant.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    case (idx)
      SEL_IN0: oh = 5'b00001;
      SEL_IN1: oh = 5'b00010;
      SEL_IN2: oh = 5'b00100;
      SEL_IN3: oh = 5'b01000;
      SEL_IN4: oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux5_rr_arbiter_rr_pick5.sv
// rtl/mux5_rr_arbiter_rr_pick5.sv - combinational round-robin winner pick over 5 requests
module rr_pick5
  import mux5_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic [SEL_W-1:0] win_idx,
  output logic             win_found
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W:0]   cand;

  // Scan last_ptr+1 .. last_ptr+5 (mod 5); the first requester seen wins.
  always_comb begin
    win_idx   = SEL_IN0;
    win_found = 1'b0;
    cand      = '0;
    ptr       = (last_ptr > SEL_IN4) ? SEL_IN4 : last_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!win_found && req[cand[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// rtl/mux5_rr_arbiter.sv - round-robin arbiter driving the select lines of a 5-input mux
module mux5_rr_arbiter
  import mux5_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             s0,
  output logic             s1,
  output logic             s2
);

  // Hold counter saturates here; with MAX_HOLD=0 it just parks at all-ones.
  localparam logic              HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}}
                                                           : HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  last_ptr_q, last_ptr_d;

  logic [SEL_W-1:0]  win_idx;
  logic              win_found;
  logic              owner_req;
  logic              other_req;
  logic              expire;

  // The pointer always equals the current owner while granted, so one picker
  // serves both the idle path and rotation (owner is scanned last).
  rr_pick5 u_pick (
    .req       (req),
    .last_ptr  (last_ptr_q),
    .win_idx   (win_idx),
    .win_found (win_found)
  );

  assign owner_req = |(req & grant_q);
  assign other_req = |(req & ~grant_q);
  assign expire    = HOLD_EN && (hold_q == HOLD_SAT) && owner_req && other_req && enable;

  // Next-state, grant, select and hold-counter computation.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    hold_d     = hold_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d    = GRANT;
          grant_d    = idx_to_onehot(win_idx);
          sel_d      = win_idx;
          hold_d     = '0;
          last_ptr_d = win_idx;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Release wins over a coincident expiry.
          if (enable && win_found) begin
            grant_d    = idx_to_onehot(win_idx);
            sel_d      = win_idx;
            hold_d     = '0;
            last_ptr_d = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            sel_d   = SEL_IN0;
            hold_d  = '0;
          end
        end else if (expire) begin
          grant_d    = idx_to_onehot(win_idx);
          sel_d      = win_idx;
          hold_d     = '0;
          last_ptr_d = win_idx;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = SEL_IN0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including mid-burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= SEL_IN0;
      hold_q     <= '0;
      last_ptr_q <= SEL_IN4;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign s0          = sel_q[2];
  assign s1          = sel_q[1];
  assign s2          = sel_q[0];

endmodule
